// File: rtl/data_sram_responder.sv
// Memory end of the data_sram port: one-cycle registered reads, byte-enable writes,
// post-reset clear sweep and sticky out-of-range capture.
module data_sram_responder #(
   parameter int unsigned ADDR_W         = 10,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        sram_ready,
   output logic        sram_err,
   output logic [31:0] sram_err_addr,
   input  logic        sram_err_clr
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;
   localparam state_t ST_INIT = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
   logic                ready_nxt;
   logic                err_nxt;
   logic [31:0]         err_addr_nxt;
   logic                err_hit;
   logic [31:0]         off_c;
   logic                in_range_c;
   logic [ADDR_W-1:0]   idx_c;
   logic [ADDR_W-1:0]   mem_idx;
   logic [3:0]          mem_be;
   logic [31:0]         mem_wd;
   logic                rd_en;

   logic [31:0]         mem [DEPTH];

   // Address decode relative to the window base; offset arithmetic wraps at 32 bits.
   always_comb begin
      off_c      = data_sram_addr - BASE_ADDR;
      in_range_c = {1'b0, off_c} < SPAN;
      idx_c      = off_c[ADDR_W+1:2];
   end

   // Next-state, memory port control and error capture.
   always_comb begin
      state_nxt    = state;
      clr_cnt_nxt  = clr_cnt;
      err_nxt      = sram_err;
      err_addr_nxt = sram_err_addr;
      err_hit      = 1'b0;
      mem_idx      = idx_c;
      mem_be       = 4'h0;
      mem_wd       = data_sram_wdata;
      rd_en        = 1'b0;

      case (state)
         ST_CLEAR: begin
            mem_idx     = clr_cnt;
            mem_be      = 4'hF;
            mem_wd      = 32'h0;
            clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (data_sram_en) begin
               if (data_sram_wen == 4'h0) rd_en = 1'b1;
               else if (in_range_c)       mem_be = data_sram_wen;
               err_hit = !in_range_c;
            end
         end
      endcase

      // A new error in the same cycle as a clear takes priority over the clear.
      if (sram_err_clr) begin
         err_nxt      = 1'b0;
         err_addr_nxt = 32'h0;
      end
      if (err_hit && (!sram_err || sram_err_clr)) begin
         err_nxt      = 1'b1;
         err_addr_nxt = data_sram_addr;
      end

      ready_nxt = (state_nxt == ST_RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_INIT;
         clr_cnt         <= '0;
         sram_ready      <= 1'b0;
         sram_err        <= 1'b0;
         sram_err_addr   <= 32'h0;
         data_sram_rdata <= 32'h0;
      end else begin
         state         <= state_nxt;
         clr_cnt       <= clr_cnt_nxt;
         sram_ready    <= ready_nxt;
         sram_err      <= err_nxt;
         sram_err_addr <= err_addr_nxt;
         if (rd_en) data_sram_rdata <= in_range_c ? mem[idx_c] : 32'h0;
      end
   end

   // Storage is deliberately not reset; the clear sweep zeroes it instead.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
      end
   end

endmodule
